// File: rtl/truth_table_checker_if.sv
// Sample stream from a function under test into the truth table checker.
// The producer drives vector/output/valid; the checker answers with ready.
interface truth_table_checker_if #(
  parameter int N = 3
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         in_s;

  modport master (output in_valid, in_vec, in_s, input in_ready);
  modport slave  (input in_valid, in_vec, in_s, output in_ready);
endinterface

// File: rtl/truth_table_checker.sv
// Rebuilds the observed truth table of a function under test from a stream of
// (input vector, output) samples and grades it against the EXPECTED minterm mask.
module truth_table_checker #(
  parameter int                N        = 3,
  parameter logic [(1<<N)-1:0] EXPECTED = 8'h54,
  parameter int                CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  truth_table_checker_if.slave  bus,
  output logic [(1<<N)-1:0]     captured,
  output logic [(1<<N)-1:0]     covered,
  output logic [CNT_W-1:0]      err_count,
  output logic                  conflict,
  output logic                  done,
  output logic                  pass
);

  localparam int ROWS = 1 << N;

  typedef enum logic [1:0] {
    S_COLLECT,
    S_REPORT,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            armed;
  logic            accept;
  logic [ROWS-1:0] vec_bit;
  logic [ROWS-1:0] covered_next;
  logic            sample_mismatch;
  logic            sample_conflict;
  logic            err_saturated;

  assign accept          = bus.in_valid & bus.in_ready;
  assign vec_bit         = ROWS'(1) << bus.in_vec;
  assign covered_next    = covered | vec_bit;
  assign sample_mismatch = bus.in_s != EXPECTED[bus.in_vec];
  assign sample_conflict = covered[bus.in_vec] & (captured[bus.in_vec] != bus.in_s);
  assign err_saturated   = err_count == {CNT_W{1'b1}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // Only the sample that fills the last uncovered minterm can end collection.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = S_COLLECT;
    end else begin
      case (state)
        S_COLLECT: if (accept && (&covered_next)) state_next = S_REPORT;
        S_REPORT:  state_next = S_DONE;
        S_DONE:    state_next = S_DONE;
        default:   state_next = S_COLLECT;
      endcase
    end
  end

  always_comb begin
    bus.in_ready = armed & (state == S_COLLECT) & ~clear;
  end

  // Holds in_ready low until the first edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      captured  <= '0;
      covered   <= '0;
      err_count <= '0;
      conflict  <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else if (clear) begin
      captured  <= '0;
      covered   <= '0;
      err_count <= '0;
      conflict  <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      if (accept) begin
        captured[bus.in_vec] <= bus.in_s;
        covered              <= covered_next;
        if (sample_conflict) conflict <= 1'b1;
        if (sample_mismatch && !err_saturated) err_count <= err_count + CNT_W'(1);
      end
      if (state == S_REPORT) begin
        done <= 1'b1;
        pass <= (captured == EXPECTED) & ~conflict & (err_count == '0);
      end
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: a reference model pushes expected
// outputs per driven cycle, and each post-edge sample pops and compares them.
module tb_truth_table_checker;

  localparam logic [7:0] EXP_MASK = 8'h54;
  localparam int M_COLLECT = 0;
  localparam int M_REPORT  = 1;
  localparam int M_DONE    = 2;

  typedef struct packed {
    logic [7:0] cap;
    logic [7:0] cov;
    logic [7:0] err;
    logic       conf;
    logic       done;
    logic       pass;
    logic       ready;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [7:0] captured;
  logic [7:0] covered;
  logic [7:0] err_count;
  logic       conflict;
  logic       done;
  logic       pass;

  int tests;
  int fails;

  exp_t sb[$];

  logic [7:0] m_cap;
  logic [7:0] m_cov;
  logic [7:0] m_err;
  logic       m_conf;
  logic       m_done;
  logic       m_pass;
  logic       m_armed;
  int         m_state;

  truth_table_checker_if #(.N(3)) bus ();

  truth_table_checker #(.N(3), .EXPECTED(8'h54), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .bus       (bus),
    .captured  (captured),
    .covered   (covered),
    .err_count (err_count),
    .conflict  (conflict),
    .done      (done),
    .pass      (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic f_xyz(input logic [2:0] v);
    return (v[2] | v[1]) & ~v[0];
  endfunction

  function automatic logic f_or(input logic [2:0] v);
    return v[2] | v[1];
  endfunction

  task automatic checkField(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    m_cap   = '0;
    m_cov   = '0;
    m_err   = '0;
    m_conf  = 1'b0;
    m_done  = 1'b0;
    m_pass  = 1'b0;
    m_armed = 1'b0;
    m_state = M_COLLECT;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL scoreboard: observed empty queue, expected an entry");
      return;
    end
    e = sb.pop_front();
    checkField("captured",  captured,      e.cap);
    checkField("covered",   covered,       e.cov);
    checkField("err_count", err_count,     e.err);
    checkField("conflict",  8'(conflict),  8'(e.conf));
    checkField("done",      8'(done),      8'(e.done));
    checkField("pass",      8'(pass),      8'(e.pass));
    checkField("in_ready",  8'(bus.in_ready), 8'(e.ready));
  endtask

  // Drive one cycle, advance the model across the edge, then compare.
  task automatic applyStimulus(input logic v, input logic [2:0] vec, input logic s, input logic clr);
    exp_t e;
    logic acc;
    bus.in_valid = v;
    bus.in_vec   = vec;
    bus.in_s     = s;
    clear        = clr;
    acc = v & m_armed & (m_state == M_COLLECT) & ~clr;
    if (clr) begin
      m_cap   = '0;
      m_cov   = '0;
      m_err   = '0;
      m_conf  = 1'b0;
      m_done  = 1'b0;
      m_pass  = 1'b0;
      m_state = M_COLLECT;
    end else if (m_state == M_COLLECT) begin
      if (acc) begin
        if (m_cov[vec] && (m_cap[vec] != s)) m_conf = 1'b1;
        m_cov[vec] = 1'b1;
        m_cap[vec] = s;
        if ((s != EXP_MASK[vec]) && (m_err != 8'hFF)) m_err = m_err + 8'd1;
        if (m_cov == 8'hFF) m_state = M_REPORT;
      end
    end else if (m_state == M_REPORT) begin
      m_done  = 1'b1;
      m_pass  = (m_cap == EXP_MASK) && !m_conf && (m_err == 8'd0);
      m_state = M_DONE;
    end
    m_armed = 1'b1;
    e.cap   = m_cap;
    e.cov   = m_cov;
    e.err   = m_err;
    e.conf  = m_conf;
    e.done  = m_done;
    e.pass  = m_pass;
    e.ready = m_armed && (m_state == M_COLLECT) && !clr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkField({tag, "_captured"},  captured,  8'h00);
    checkField({tag, "_covered"},   covered,   8'h00);
    checkField({tag, "_err_count"}, err_count, 8'h00);
    checkField({tag, "_conflict"},  8'(conflict), 8'h00);
    checkField({tag, "_done"},      8'(done),  8'h00);
    checkField({tag, "_pass"},      8'(pass),  8'h00);
    checkField({tag, "_in_ready"},  8'(bus.in_ready), 8'h00);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n        = 1'b0;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_vec   = 3'd0;
    bus.in_s     = 1'b0;
    resetModel();

    #12;
    checkAllZero("reset");
    rst_n = 1'b1;
    idle(1);

    // Exhaustive pass with (x|y)&~z.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(i), f_xyz(3'(i)), 1'b0);
    checkField("pass_ready_after_8th", 8'(bus.in_ready), 8'h00);
    idle(2);
    checkField("pass_captured", captured, 8'h54);
    checkField("pass_covered", covered, 8'hFF);
    checkField("pass_err", err_count, 8'h00);
    checkField("pass_done", 8'(done), 8'h01);
    checkField("pass_pass", 8'(pass), 8'h01);

    // Backpressure in DONE, then clear together with a valid sample.
    applyStimulus(1'b1, 3'd5, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd5, 1'b1, 1'b0);
    checkField("bp_captured", captured, 8'h54);
    checkField("bp_err", err_count, 8'h00);
    applyStimulus(1'b1, 3'd5, 1'b1, 1'b1);
    checkAllZero("clear");
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    checkField("clear_ready", 8'(bus.in_ready), 8'h01);
    checkField("clear_dropped", covered, 8'h00);

    // Wrong function x|y.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(i), f_or(3'(i)), 1'b0);
    idle(2);
    checkField("wrong_captured", captured, 8'hFC);
    checkField("wrong_err", err_count, 8'd3);
    checkField("wrong_done", 8'(done), 8'h01);
    checkField("wrong_pass", 8'(pass), 8'h00);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);

    // Conflicting repeat on minterm 2.
    applyStimulus(1'b1, 3'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(i), f_xyz(3'(i)), 1'b0);
    idle(2);
    checkField("conf_conflict", 8'(conflict), 8'h01);
    checkField("conf_err", err_count, 8'd1);
    checkField("conf_captured", captured, 8'h54);
    checkField("conf_pass", 8'(pass), 8'h00);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);

    // Reverse order with idle gaps.
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b1, 3'(i), f_xyz(3'(i)), 1'b0);
      if (i == 1) checkField("rev_not_done_early", 8'(done), 8'h00);
      applyStimulus(1'b0, 3'(i), 1'b0, 1'b0);
    end
    idle(1);
    checkField("rev_done", 8'(done), 8'h01);
    checkField("rev_pass", 8'(pass), 8'h01);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);

    // Error counter saturation via repeated wrong samples on one minterm.
    for (int i = 0; i < 260; i++) applyStimulus(1'b1, 3'd0, 1'b1, 1'b0);
    checkField("sat_err", err_count, 8'hFF);
    checkField("sat_conflict", 8'(conflict), 8'h00);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);

    // Asynchronous reset part way through a session.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 3'(i), f_xyz(3'(i)), 1'b0);
    checkField("async_pre_covered", covered, 8'h0F);
    #3;
    rst_n = 1'b0;
    #1;
    checkAllZero("async");
    resetModel();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(i), f_xyz(3'(i)), 1'b0);
    idle(2);
    checkField("async_post_pass", 8'(pass), 8'h01);
    checkField("async_post_done", 8'(done), 8'h01);

    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("[TB] FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Response-side counterpart to the exhaustive stimulus sequences used on the guia_04 gate-level function blocks (e.g. fxyz, s = (x|y)&~z).
- Sits on the output side of a function under test. It accepts a stream of (input vector, observed output) samples through a valid/ready handshake and rebuilds the observed truth table as a minterm mask.
- Tracks which minterms have been seen, detects conflicting repeats, and compares the observed table against a parameterised expected table.
- Reports done/pass once every minterm has been observed.

Parameters:
- N, 3: number of function inputs; the table has 2^N rows.
- EXPECTED, 8'h54: expected minterm mask, width 2^N. Bit i is the expected output for input vector i, with the MSB of the vector being the first input. The default encodes (x|y)&~z: minterms 2, 4, 6.
- CNT_W, 8: width of the error counter.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- clear, input, 1: synchronous restart of a checking session.
- in_valid, input, 1: sample present.
- in_ready, output, 1: checker can accept a sample.
- in_vec, input, N: input vector applied to the function under test.
- in_s, input, 1: output observed for in_vec.
- captured, output, 2^N: observed output per minterm; bit valid only where covered=1.
- covered, output, 2^N: minterm seen at least once.
- err_count, output, CNT_W: accepted samples whose in_s differs from EXPECTED[in_vec]; saturating.
- conflict, output, 1: sticky; a minterm was seen twice with different outputs.
- done, output, 1: all minterms covered and report complete.
- pass, output, 1: result, valid only while done=1.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are 0, including captured, covered, err_count, conflict, done, pass and in_ready. State is COLLECT. On the first edge after release, in_ready=1.
- States:
  - COLLECT: in_ready = ~clear.
  - REPORT: in_ready=0; lasts exactly 1 cycle.
  - DONE: in_ready=0; held until clear.
- Accept rule: a sample is accepted on a rising edge where in_valid & in_ready. While in_ready=0, in_vec, in_s and in_valid are ignored.
- On an accepted sample, all of the following register on that same edge (1-cycle latency to outputs):
  - covered[in_vec] <= 1; captured[in_vec] <= in_s.
  - If covered[in_vec] was already 1 and captured[in_vec] != in_s: conflict <= 1. The new value still overwrites captured.
  - If in_s != EXPECTED[in_vec]: err_count increments, saturating at 2^CNT_W-1.
- Transitions:
  - COLLECT -> REPORT on the edge where an accepted sample makes covered all ones.
  - REPORT -> DONE on the next edge. That same edge sets done=1 and pass = (captured==EXPECTED) & ~conflict & (err_count==0).
  - DONE -> COLLECT on clear.
- clear (synchronous, any state): on the edge, all outputs except in_ready are zeroed and state goes to COLLECT.
  - clear has priority over a simultaneous in_valid; that sample is not accepted, because in_ready is low while clear is high.
- Repeat samples in COLLECT are legal. A repeat never re-triggers the transition to REPORT by itself.
- N=1 edge case: the table has 2 rows; the behaviour above is unchanged.
- Reset mid-session: asynchronous clear of everything; the partial table is lost.
- X/Z on in_s or in_vec is not supported. The checker treats it as undefined, and the bench must not drive it while in_valid=1.

Test Plan:
- Exhaustive pass:
  - Stimulus: after reset, drive vectors 0..7 in order with in_s = (x|y)&~z, i.e. s=0,0,1,0,1,0,1,0, one per cycle.
  - Response: captured=8'h54, covered=8'hFF, err_count=0, in_ready=0 from the cycle after the 8th sample, done=1 and pass=1 two edges after the 8th accept.
- Wrong function:
  - Stimulus: same vectors with in_s = x|y (0,0,1,1,1,1,1,1).
  - Response: captured=8'hFC, err_count=3, done=1, pass=0.
- Conflict:
  - Stimulus: vec 2 with s=1, then vec 2 with s=0, then vecs 0..7 correct.
  - Response: conflict=1, err_count=1, pass=0, captured=8'h54.
- Backpressure:
  - Stimulus: hold in_valid=1 with vec 5, s=1 while the checker is in DONE.
  - Response: in_ready=0 and no change in err_count or captured.
  - Stimulus: pulse clear together with in_valid.
  - Response: all outputs 0, sample dropped, in_ready=1 on the next cycle.
- Reverse/random order with idle gaps:
  - Stimulus: vectors 7..0 with in_valid toggled off between samples.
  - Response: done occurs only after the 8th distinct vector; pass=1.
- Async reset mid-session:
  - Stimulus: assert rst_n=0 between clock edges after 4 samples.
  - Response: outputs are 0 immediately, without waiting for a clock edge.
  - Stimulus: after release, send a full correct sequence.
  - Response: pass=1.
